// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard: shift register of in-flight destination tags,
// youngest-producer forward select, load-use stall. Optional stall counter: FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned AW       = 5,
    parameter int unsigned LOAD_LAT = 1,
    localparam int unsigned SW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]    id_src_used,
    input  logic [AW-1:0]         id_dst,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall,
    output logic [NUM_SRC-1:0]    fwd_en,
    output logic [NUM_SRC*SW-1:0] fwd_sel,
    output logic [31:0]           stall_cnt
);

    logic [DEPTH:1]  v_q, v_d;
    logic [DEPTH:1]  ld_q, ld_d;
    logic [AW-1:0]   dst_q [1:DEPTH];
    logic [AW-1:0]   dst_d [1:DEPTH];

    logic            stall_req;
    logic            found;
    logic [AW-1:0]   src;
    logic            issue;

    // Slot 1 is the youngest; the first match from slot 1 upward is the producer.
    always_comb begin
        stall_req = 1'b0;
        fwd_en    = '0;
        fwd_sel   = '0;
        found     = 1'b0;
        src       = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src   = id_src[i*AW +: AW];
            found = 1'b0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found && id_src_used[i] && (src != '0) && v_q[k] && (dst_q[k] == src)) begin
                    found = 1'b1;
                    if (ld_q[k] && (k <= LOAD_LAT)) begin
                        stall_req = 1'b1;
                    end else begin
                        fwd_en[i]            = 1'b1;
                        fwd_sel[i*SW +: SW]  = SW'(k);
                    end
                end
            end
        end
    end

    assign stall = stall_req && id_valid && !flush && !hold;
    assign issue = id_valid && !flush && !stall;

    always_comb begin
        v_d  = v_q;
        ld_d = ld_q;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            dst_d[k] = dst_q[k];
        end
        if (!hold) begin
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                v_d[k]   = v_q[k-1];
                ld_d[k]  = ld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            v_d[1]   = issue && id_we && (id_dst != '0);
            ld_d[1]  = issue && id_is_load;
            dst_d[1] = id_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            ld_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            v_q  <= v_d;
            ld_q <= ld_d;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                dst_q[k] <= dst_d[k];
            end
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed hazard scenarios plus random traffic,
// expectations from a queue-based pipeline model, checked by a separate negedge monitor.
module tb_fwd_scoreboard;

    localparam int unsigned NSRC = 2;
    localparam int unsigned DEP  = 2;
    localparam int unsigned AWID = 5;
    localparam int unsigned LLAT = 1;
    localparam int unsigned SWID = 2;

    logic                   clk;
    logic                   rst;
    logic                   id_valid;
    logic [NSRC*AWID-1:0]   id_src;
    logic [NSRC-1:0]        id_src_used;
    logic [AWID-1:0]        id_dst;
    logic                   id_we;
    logic                   id_is_load;
    logic                   hold;
    logic                   flush;
    logic                   stall;
    logic [NSRC-1:0]        fwd_en;
    logic [NSRC*SWID-1:0]   fwd_sel;
    logic [31:0]            stall_cnt;

    fwd_scoreboard #(
        .NUM_SRC  (NSRC),
        .DEPTH    (DEP),
        .AW       (AWID),
        .LOAD_LAT (LLAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_dst      (id_dst),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .hold        (hold),
        .flush       (flush),
        .stall       (stall),
        .fwd_en      (fwd_en),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] dst;
        bit       ld;
    } mslot_t;

    typedef struct {
        bit        st;
        bit [1:0]  en;
        bit [3:0]  sel;
        bit [31:0] cnt;
        string     tag;
    } exp_t;

    mslot_t    pipe[$];   // pipe[0] = youngest in-flight instruction
    exp_t      sb[$];
    bit [31:0] cnt_m;
    int        total = 0;
    int        bad   = 0;

    function automatic void model_clear();
        mslot_t e;
        e.v = 1'b0; e.dst = '0; e.ld = 1'b0;
        pipe.delete();
        for (int n = 0; n < int'(DEP); n++) pipe.push_back(e);
    endfunction

    // mode 0: no check, 1: model expectation, 2: explicit expectation (xst/xen/xsel)
    task automatic cyc(input bit v, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] u,
                       input bit [4:0] d, input bit we, input bit ld, input bit hd, input bit fl,
                       input bit r, input int mode, input bit xst, input bit [1:0] xen,
                       input bit [3:0] xsel, input string tag);
        bit        mst;
        bit        pend;
        bit [1:0]  men;
        bit [3:0]  msel;
        bit [4:0]  s;
        exp_t      e;
        mslot_t    ns;
        id_valid = v; id_src = {s1, s0}; id_src_used = u; id_dst = d;
        id_we = we; id_is_load = ld; hold = hd; flush = fl; rst = r;
        pend = 1'b0; men = '0; msel = '0;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? s0 : s1;
            if (u[i] && s != 0) begin
                for (int age = 1; age <= int'(DEP); age++) begin
                    if (pipe[age-1].v && pipe[age-1].dst == s) begin
                        if (pipe[age-1].ld && age <= int'(LLAT)) pend = 1'b1;
                        else begin
                            men[i] = 1'b1;
                            msel[i*2 +: 2] = 2'(age);
                        end
                        break;
                    end
                end
            end
        end
        mst = v && !fl && !hd && pend;
        if (mode != 0) begin
            e.st  = (mode == 2) ? xst  : mst;
            e.en  = (mode == 2) ? xen  : men;
            e.sel = (mode == 2) ? xsel : msel;
`ifdef FWD_SCOREBOARD_STATS_EN
            e.cnt = cnt_m;
`else
            e.cnt = 32'd0;
`endif
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            model_clear();
            cnt_m = 32'd0;
        end else if (!hd) begin
            ns.v   = v && !fl && !mst && we && (d != 0);
            ns.dst = d;
            ns.ld  = ld;
            pipe.push_front(ns);
            void'(pipe.pop_back());
            if (mst && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (stall !== e.st) begin
                bad++;
                $display("FAIL %s stall: got %0b want %0b", e.tag, stall, e.st);
            end
            total++;
            if (fwd_en !== e.en) begin
                bad++;
                $display("FAIL %s fwd_en: got %b want %b", e.tag, fwd_en, e.en);
            end
            total++;
            if (fwd_sel !== e.sel) begin
                bad++;
                $display("FAIL %s fwd_sel: got %b want %b", e.tag, fwd_sel, e.sel);
            end
            total++;
            if (stall_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.tag, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] cnt_after_load;
        cnt_m = 32'd0;
        model_clear();
        id_valid = 0; id_src = '0; id_src_used = '0; id_dst = '0;
        id_we = 0; id_is_load = 0; hold = 0; flush = 0; rst = 1;
        @(posedge clk); #1;
        //      v  s0 s1 u      d  we ld hd fl r  mode st en     sel
        cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, "rst");
        cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, "rst");
        cyc(1, 8, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b00, 4'b0000, "reset_state");
        // EX / MEM forwarding
        cyc(1, 0, 0, 2'b00, 8, 1, 0, 0, 0, 0, 2, 0, 2'b00, 4'b0000, "issue_add8");
        cyc(1, 8, 9, 2'b11, 0, 0, 0, 0, 0, 0, 2, 0, 2'b01, 4'b0001, "ex_fwd");
        cyc(1, 0, 8, 2'b10, 0, 0, 0, 0, 0, 0, 2, 0, 2'b10, 4'b1000, "mem_fwd");
        // youngest producer wins
        cyc(1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue5a");
        cyc(1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue5b");
        cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b01, 4'b0001, "youngest");
        // load-use: exactly one stall cycle
        cyc(1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue_ld4");
        cyc(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 1, 2'b00, 4'b0000, "load_use_stall");
        cyc(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b01, 4'b0010, "load_use_fwd");
        cnt_after_load = cnt_m;
`ifdef FWD_SCOREBOARD_STATS_EN
        total++;
        if (stall_cnt !== 32'd1 || cnt_after_load !== 32'd1) begin
            bad++;
            $display("FAIL stall_cnt_after_load: got %0d want 1", stall_cnt);
        end
`else
        total++;
        if (stall_cnt !== 32'd0) begin
            bad++;
            $display("FAIL stall_cnt_tied: got %0d want 0", stall_cnt);
        end
`endif
        // register 0 never forwards
        cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue_r0");
        cyc(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b00, 4'b0000, "r0_nofwd");
        // hold freezes slots
        cyc(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue3");
        for (int n = 0; n < 3; n++)
            cyc(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 4'b0000, "hold");
        cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b01, 4'b0001, "after_hold");
        // flush beats a pending stall
        cyc(1, 0, 0, 2'b00, 6, 1, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue_ld6");
        cyc(1, 6, 0, 2'b01, 0, 0, 0, 0, 1, 0, 2, 0, 2'b00, 4'b0000, "flush_stall");
        cyc(1, 6, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b01, 4'b0010, "after_flush");
        // hold suppresses stall
        cyc(1, 0, 0, 2'b00, 2, 1, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue_ld2");
        cyc(1, 2, 0, 2'b01, 0, 0, 0, 1, 0, 0, 2, 0, 2'b00, 4'b0000, "hold_nostall");
        cyc(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 1, 2'b00, 4'b0000, "stall_after_hold");
        // reset mid-stall
        cyc(1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 1, 0, 2'b00, 4'b0000, "issue_ld7");
        cyc(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 2, 1, 2'b00, 4'b0000, "rst_mid_stall");
        cyc(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 2, 0, 2'b00, 4'b0000, "post_rst");
        // random traffic over a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(9) != 0),
                5'($urandom_range(7)), 5'($urandom_range(7)), 2'($urandom_range(3)),
                5'($urandom_range(7)), 1'($urandom_range(3) != 0), 1'($urandom_range(2) == 0),
                1'($urandom_range(9) == 0), 1'($urandom_range(9) == 0),
                1'($urandom_range(199) == 0), 1, 0, 2'b00, 4'b0000, "rand");
        end
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
